// File: rtl/timebase_pkg.sv
// Shared timebase constants and the divider-ratio helper used by the slow strobe generators.
`timescale 1ns/1ps
package timebase_pkg;

  localparam int SYS_CLK_HZ  = 4_000_000;
  localparam int TICK_5MS_US = 5000;

  // Number of input clocks per half output period; 64-bit math because freq*period overflows int.
  function automatic int half_cycles(input longint freq, input longint period_us);
    return int'((freq * period_us) / longint'(2_000_000));
  endfunction

endpackage

// File: rtl/clock_5ms_gen_if.sv
// Output bundle of the 5 ms timebase: square wave and its registered complement.
`timescale 1ns/1ps
interface clock_5ms_gen_if;

  logic clk_5ms;
  logic clk_not_5ms;

  modport master (output clk_5ms, output clk_not_5ms);
  modport slave  (input  clk_5ms, input  clk_not_5ms);

endinterface

// File: rtl/clk_div_counter.sv
// Free-running modulo-N counter; wrap_o is high during the terminal count cycle.
`timescale 1ns/1ps
module clk_div_counter #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic wrap_o
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign wrap_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = wrap_o ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clock_5ms_gen.sv
// 200 Hz square wave and complement derived from the 4 MHz system clock.
// Outputs are strobes for enable/edge-detect use, never for a clock tree.
`timescale 1ns/1ps
module clock_5ms_gen
  import timebase_pkg::*;
#(
  parameter int CLK_FREQ_HZ = SYS_CLK_HZ,
  parameter int PERIOD_US   = TICK_5MS_US
) (
  input  logic             clk_4mhz,
  input  logic             reset,
  clock_5ms_gen_if.master  out_if
);

  localparam int     HALF_CYCLES = half_cycles(CLK_FREQ_HZ, PERIOD_US);
  localparam int     CNT_W       = $clog2(HALF_CYCLES);
  localparam longint PRODUCT     = longint'(CLK_FREQ_HZ) * longint'(PERIOD_US);

  generate
    if (HALF_CYCLES < 2 || (PRODUCT % longint'(2_000_000)) != 0) begin : g_bad_cfg
      $error("clock_5ms_gen: ratio must be an exact integer half period of at least 2 clocks");
    end
  endgenerate

  logic wrap;
  logic clk_q;
  logic clk_d;
  logic clk_n_q;
  logic clk_n_d;

  clk_div_counter #(
    .N (HALF_CYCLES),
    .W (CNT_W)
  ) u_cnt (
    .clk_i  (clk_4mhz),
    .rst_i  (reset),
    .wrap_o (wrap)
  );

  // Complement is its own flop so both outputs share the same clock-to-out.
  always_comb begin
    clk_d   = clk_q ^ wrap;
    clk_n_d = ~clk_d;
  end

  always_ff @(posedge clk_4mhz or posedge reset) begin
    if (reset) begin
      clk_q   <= 1'b0;
      clk_n_q <= 1'b1;
    end else begin
      clk_q   <= clk_d;
      clk_n_q <= clk_n_d;
    end
  end

  assign out_if.clk_5ms     = clk_q;
  assign out_if.clk_not_5ms = clk_n_q;

endmodule

// File: tb/tb_clock_5ms_gen.sv
// Bench for clock_5ms_gen: default 5 ms instance plus a 1 MHz / 10 us instance (half period 5).
`timescale 1ns/1ps
module tb_clock_5ms_gen;

  localparam int H_M = 10000;
  localparam int H_S = 5;

  logic clk_4mhz = 1'b0;
  logic rst_m    = 1'b0;
  logic rst_s    = 1'b0;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  // Reference: output level is the parity of whole half periods since reset release.
  int k_m = 0;
  int k_s = 0;

  clock_5ms_gen_if m_if ();
  clock_5ms_gen_if s_if ();

  clock_5ms_gen dut_m (
    .clk_4mhz (clk_4mhz),
    .reset    (rst_m),
    .out_if   (m_if)
  );

  clock_5ms_gen #(
    .CLK_FREQ_HZ (1_000_000),
    .PERIOD_US   (10)
  ) dut_s (
    .clk_4mhz (clk_4mhz),
    .reset    (rst_s),
    .out_if   (s_if)
  );

  always #125 clk_4mhz = ~clk_4mhz;

  always @(posedge clk_4mhz or posedge rst_m)
    if (rst_m) k_m <= 0; else k_m <= k_m + 1;

  always @(posedge clk_4mhz or posedge rst_s)
    if (rst_s) k_s <= 0; else k_s <= k_s + 1;

  function automatic logic model_lvl(input int k, input int h);
    return ((k / h) % 2) == 1;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Continuous model comparison, including the complement invariant.
  always @(negedge clk_4mhz) begin
    chk("run_m_clk", m_if.clk_5ms, model_lvl(k_m, H_M));
    chk("run_m_not", m_if.clk_not_5ms, ~model_lvl(k_m, H_M));
    chk("run_s_clk", s_if.clk_5ms, model_lvl(k_s, H_S));
    chk("run_s_not", s_if.clk_not_5ms, ~model_lvl(k_s, H_S));
  end

  typedef struct {
    int   run;
    logic exp_m;
    logic exp_s;
  } vec_t;

  vec_t tbl[7];

  int   rise_at[2];
  int   fall_at;
  int   n_rise;
  int   n_fall;
  logic prev;
  int   hold;

  initial begin
    tbl[0] = '{run: 0,     exp_m: 1'b0, exp_s: 1'b0};
    tbl[1] = '{run: 3,     exp_m: 1'b0, exp_s: 1'b0};
    tbl[2] = '{run: 5,     exp_m: 1'b0, exp_s: 1'b1};
    tbl[3] = '{run: 9,     exp_m: 1'b0, exp_s: 1'b1};
    tbl[4] = '{run: 10,    exp_m: 1'b0, exp_s: 1'b0};
    tbl[5] = '{run: 17,    exp_m: 1'b0, exp_s: 1'b1};
    tbl[6] = '{run: 10000, exp_m: 1'b1, exp_s: 1'b0};

    // Power-on: 1 us of reset.
    rst_m = 1'b1;
    rst_s = 1'b1;
    #1;
    chk("por_clk", m_if.clk_5ms, 1'b0);
    chk("por_not", m_if.clk_not_5ms, 1'b1);
    repeat (4) @(negedge clk_4mhz);

    // Table: reset, release, run N edges, compare both instances.
    for (int i = 0; i < 7; i++) begin
      #5;
      rst_m = 1'b1;
      rst_s = 1'b1;
      @(negedge clk_4mhz);
      #5;
      rst_m = 1'b0;
      rst_s = 1'b0;
      repeat (tbl[i].run) @(negedge clk_4mhz);
      #1;
      chk("tbl_m_clk", m_if.clk_5ms, tbl[i].exp_m);
      chk("tbl_m_not", m_if.clk_not_5ms, ~tbl[i].exp_m);
      chk("tbl_s_clk", s_if.clk_5ms, tbl[i].exp_s);
      chk("tbl_s_not", s_if.clk_not_5ms, ~tbl[i].exp_s);
      @(negedge clk_4mhz);
    end

    // Free run of the main divider: edge positions after release.
    #5;
    rst_m = 1'b1;
    @(negedge clk_4mhz);
    #5;
    rst_m = 1'b0;
    prev = m_if.clk_5ms;
    n_rise = 0;
    n_fall = 0;
    rise_at = '{-1, -1};
    fall_at = -1;
    for (int c = 1; c <= 31000; c++) begin
      @(negedge clk_4mhz);
      if (!prev && m_if.clk_5ms && n_rise < 2) begin
        rise_at[n_rise] = c;
        n_rise++;
      end
      if (prev && !m_if.clk_5ms && n_fall < 1) begin
        fall_at = c;
        n_fall++;
      end
      prev = m_if.clk_5ms;
    end
    chk("first_rise_10000", rise_at[0] == 10000, 1'b1);
    chk("first_fall_20000", fall_at == 20000, 1'b1);
    chk("period_20000", (rise_at[1] - rise_at[0]) == 20000, 1'b1);
    chk("high_time_10000", (fall_at - rise_at[0]) == 10000, 1'b1);

    // Reset mid-period while high: asynchronous forced transition.
    chk("pre_rst_high", m_if.clk_5ms, 1'b1);
    #60;
    rst_m = 1'b1;
    #1;
    chk("async_rst_clk", m_if.clk_5ms, 1'b0);
    chk("async_rst_not", m_if.clk_not_5ms, 1'b1);
    hold = $urandom_range(20, 200);
    repeat (hold) @(negedge clk_4mhz);
    #5;
    rst_m = 1'b0;
    rise_at[0] = -1;
    prev = m_if.clk_5ms;
    for (int c = 1; c <= 10001; c++) begin
      @(negedge clk_4mhz);
      if (!prev && m_if.clk_5ms && rise_at[0] < 0) rise_at[0] = c;
      prev = m_if.clk_5ms;
    end
    chk("rerelease_rise_10000", rise_at[0] == 10000, 1'b1);

    // Randomised reset pulses at arbitrary sub-cycle offsets on the small divider.
    for (int r = 0; r < 12; r++) begin
      repeat ($urandom_range(0, 40)) @(negedge clk_4mhz);
      #($urandom_range(1, 120));
      rst_s = 1'b1;
      #1;
      chk("rand_rst_s_clk", s_if.clk_5ms, 1'b0);
      chk("rand_rst_s_not", s_if.clk_not_5ms, 1'b1);
      repeat ($urandom_range(1, 5)) @(negedge clk_4mhz);
      #5;
      rst_s = 1'b0;
    end

    // Reset landing exactly on the terminal-count edge: no extra toggle, count restarts at 0.
    @(negedge clk_4mhz);
    #5;
    rst_s = 1'b1;
    @(negedge clk_4mhz);
    #5;
    rst_s = 1'b0;
    repeat (4) @(negedge clk_4mhz);
    @(posedge clk_4mhz);
    rst_s = 1'b1;
    #1;
    chk("tc_rst_clk", s_if.clk_5ms, 1'b0);
    chk("tc_rst_not", s_if.clk_not_5ms, 1'b1);
    repeat (2) @(negedge clk_4mhz);
    #5;
    rst_s = 1'b0;
    repeat (4) @(negedge clk_4mhz);
    #1;
    chk("tc_after_4", s_if.clk_5ms, 1'b0);
    @(negedge clk_4mhz);
    #1;
    chk("tc_after_5", s_if.clk_5ms, 1'b1);
    chk("tc_after_5_not", s_if.clk_not_5ms, 1'b0);

    repeat (3) @(negedge clk_4mhz);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
